// File: rtl/sqrt_sched_pkg.sv
// Shared constants and helpers for the round-robin sqrt scheduler.
package sqrt_sched_pkg;

   localparam int SQ_W = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/sqrt_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    gnt_idx,
   output logic             any
);

   logic [IW:0] pos;
   logic        found;

   assign any = |req;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      pos     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(N_REQ)) pos = pos - (IW+1)'(N_REQ);
         if (!found && req[pos[IW-1:0]]) begin
            found               = 1'b1;
            gnt[pos[IW-1:0]]    = 1'b1;
            gnt_idx             = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/sqrt_rr_sched.sv
// Shares one square-root unit among N_REQ requesters, one request in flight.
module sqrt_rr_sched
   import sqrt_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int W       = SQ_W,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_d,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [W-1:0]       rsp_q,
   output logic               rsp_err,
   input  logic [N_REQ-1:0]   rsp_ack,
   output logic [W-1:0]       sq_d,
   output logic               sq_start,
   input  logic               sq_busy,
   input  logic               sq_ready,
   input  logic [W-1:0]       sq_q
);

   localparam int IW = idx_w(N_REQ);
   localparam int TW = idx_w(TIMEOUT);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [W-1:0]     sq_d_q, sq_d_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [W-1:0]     rsp_q_q, rsp_q_d;
   logic             rsp_err_q, rsp_err_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;

   logic [N_REQ-1:0] req_ready_c;
   logic             sq_start_c;
   logic [N_REQ-1:0] arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic             arb_any;
   logic [W-1:0]     req_op [N_REQ];

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   always_comb begin
      for (int k = 0; k < N_REQ; k++) req_op[k] = req_d[k*W +: W];
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      sq_d_d      = sq_d_q;
      tmo_cnt_d   = tmo_cnt_q;
      rsp_q_d     = rsp_q_q;
      rsp_err_d   = rsp_err_q;
      rsp_valid_d = rsp_valid_q;
      req_ready_c = '0;
      sq_start_c  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               req_ready_c = arb_gnt;
               sq_d_d      = req_op[arb_idx];
               owner_d     = arb_idx;
               rr_ptr_d    = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!sq_busy) begin
               sq_start_c = 1'b1;
               tmo_cnt_d  = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A result arriving on the last timeout cycle still counts.
            if (sq_ready) begin
               rsp_q_d     = sq_q;
               rsp_err_d   = 1'b0;
               rsp_valid_d = N_REQ'(1) << owner_q;
               state_d     = ST_RESP;
            end else if (tmo_cnt_q == TMO_LAST) begin
               rsp_q_d     = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = N_REQ'(1) << owner_q;
               state_d     = ST_RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ack[owner_q]) begin
               rsp_valid_d = '0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         sq_d_q      <= '0;
         tmo_cnt_q   <= '0;
         rsp_q_q     <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         sq_d_q      <= sq_d_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rsp_q_q     <= rsp_q_d;
         rsp_err_q   <= rsp_err_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Pulses are suppressed while reset is held so nothing leaks out.
   assign req_ready = reset ? '0 : req_ready_c;
   assign sq_start  = sq_start_c & ~reset;
   assign rsp_valid = rsp_valid_q;
   assign rsp_q     = rsp_q_q;
   assign rsp_err   = rsp_err_q;
   assign sq_d      = sq_d_q;

endmodule

// File: tb/tb_sqrt_rr_sched.sv
// Scoreboard bench for sqrt_rr_sched with a behavioural sqrt unit.
module tb_sqrt_rr_sched;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int LAT = 5;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_d = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_q;
   logic           rsp_err;
   logic [N-1:0]   rsp_ack = '0;
   logic [W-1:0]   sq_d;
   logic           sq_start;
   logic           sq_busy;
   logic           sq_ready;
   logic [W-1:0]   sq_q;

   logic           stub_busy = 1'b0;
   logic           stub_rdy = 1'b0;
   logic [W-1:0]   stub_q = '0;
   logic [W-1:0]   stub_op = '0;
   int             stub_cnt = 0;
   logic           stub_dead = 1'b0;
   logic           hold_busy = 1'b0;
   logic           stray = 1'b0;

   assign sq_busy  = stub_busy | hold_busy;
   assign sq_ready = stub_rdy | stray;
   assign sq_q     = stray ? 32'h1234_5678 : stub_q;

   sqrt_rr_sched #(.N_REQ(N), .W(W), .TIMEOUT(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_d     (req_d),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_q     (rsp_q),
      .rsp_err   (rsp_err),
      .rsp_ack   (rsp_ack),
      .sq_d      (sq_d),
      .sq_start  (sq_start),
      .sq_busy   (sq_busy),
      .sq_ready  (sq_ready),
      .sq_q      (sq_q)
   );

   always #35 clk = ~clk;

   function automatic logic [31:0] isqrt(input logic [31:0] d);
      logic [63:0] x;
      logic [31:0] r;
      logic [31:0] t;
      x = {d, 32'h0};
      r = '0;
      for (int b = 31; b >= 0; b--) begin
         t = r | (32'h1 << b);
         if ({32'h0, t} * {32'h0, t} <= x) r = t;
      end
      return r;
   endfunction

   // Sqrt unit model: busy for LAT cycles, then a one-cycle ready pulse.
   always @(posedge clk) begin
      stub_rdy <= 1'b0;
      if (stub_busy) begin
         if (stub_cnt == 0) begin
            stub_busy <= 1'b0;
            stub_rdy  <= 1'b1;
            stub_q    <= isqrt(stub_op);
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end else if (sq_start && !stub_dead) begin
         stub_busy <= 1'b1;
         stub_cnt  <= LAT - 1;
         stub_op   <= sq_d;
      end
   end

   typedef struct {
      int          idx;
      logic [31:0] q;
      logic        err;
      int          tol;
      int          lat;
   } rsp_t;

   rsp_t rq[$];
   int   gq[$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          gnt_cyc = 0;
   int          starts = 0;
   logic        rst_prev = 1'b0;
   logic        seen = 1'b0;
   logic        done = 1'b0;
   logic        done_chk = 1'b0;
   logic [N-1:0] h_v = '0;
   logic [31:0] h_q = '0;
   logic        h_e = 1'b0;

   always @(negedge clk) begin
      rsp_t        e;
      int          g;
      logic [31:0] dq;
      cyc++;
      if (rst_prev) begin
         n_cmp++;
         if ({req_ready, rsp_valid, rsp_q, rsp_err, sq_start, sq_d} != '0) begin
            n_bad++;
            $display("FAIL reset_zero: rdy=%b vld=%b q=%h err=%b st=%b d=%h, want all 0",
                     req_ready, rsp_valid, rsp_q, rsp_err, sq_start, sq_d);
         end
      end
      if (sq_start) begin
         starts++;
         n_cmp++;
         if (sq_busy) begin
            n_bad++;
            $display("FAIL start_busy: sq_start=1 with sq_busy=1 at cycle %0d", cyc);
         end
      end
      if (req_ready != '0) begin
         gnt_cyc = cyc;
         n_cmp++;
         if (gq.size() == 0) begin
            n_bad++;
            $display("FAIL grant_extra: req_ready=%b, want none", req_ready);
         end else begin
            g = gq.pop_front();
            if (req_ready != (4'b0001 << g)) begin
               n_bad++;
               $display("FAIL grant: req_ready=%b, want %b", req_ready, 4'b0001 << g);
            end
         end
      end
      if (rsp_valid != '0) begin
         n_cmp++;
         if (req_ready != '0) begin
            n_bad++;
            $display("FAIL grant_in_rsp: req_ready=%b, want 0000", req_ready);
         end
         if (!seen) begin
            seen = 1'b1;
            h_v  = rsp_valid;
            h_q  = rsp_q;
            h_e  = rsp_err;
            if (rq.size() == 0) begin
               n_bad++;
               $display("FAIL rsp_extra: rsp_valid=%b, want none", rsp_valid);
            end else begin
               e = rq.pop_front();
               n_cmp++;
               if (rsp_valid != (4'b0001 << e.idx)) begin
                  n_bad++;
                  $display("FAIL rsp_owner: rsp_valid=%b, want %b", rsp_valid, 4'b0001 << e.idx);
               end
               dq = (rsp_q >= e.q) ? rsp_q - e.q : e.q - rsp_q;
               n_cmp++;
               if (dq > 32'(e.tol)) begin
                  n_bad++;
                  $display("FAIL rsp_q: got %h, want %h +/- %0d", rsp_q, e.q, e.tol);
               end
               n_cmp++;
               if (rsp_err != e.err) begin
                  n_bad++;
                  $display("FAIL rsp_err: got %b, want %b", rsp_err, e.err);
               end
               if (e.lat >= 0) begin
                  n_cmp++;
                  if (cyc - gnt_cyc != e.lat) begin
                     n_bad++;
                     $display("FAIL latency: got %0d cycles, want %0d", cyc - gnt_cyc, e.lat);
                  end
               end
               n_cmp++;
               if (starts != 1) begin
                  n_bad++;
                  $display("FAIL start_count: got %0d starts, want 1", starts);
               end
            end
            starts = 0;
         end else begin
            n_cmp++;
            if ({rsp_valid, rsp_q, rsp_err} != {h_v, h_q, h_e}) begin
               n_bad++;
               $display("FAIL rsp_hold: got %b/%h/%b, want %b/%h/%b",
                        rsp_valid, rsp_q, rsp_err, h_v, h_q, h_e);
            end
         end
      end else begin
         seen = 1'b0;
      end
      if (reset) begin
         seen   = 1'b0;
         starts = 0;
      end
      if (done && !done_chk) begin
         done_chk = 1'b1;
         n_cmp++;
         if (gq.size() != 0 || rq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d grants, %0d rsps pending, want 0/0", gq.size(), rq.size());
         end
      end
      rst_prev = reset;
   end

   logic [N-1:0] got = '0;
   logic [N-1:0] rv = '0;

   task automatic tick();
      @(negedge clk);
      got = req_ready;
      rv  = rsp_valid;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~got;
   endtask

   task automatic put(input int idx, input logic [31:0] d);
      req_d[idx*W +: W] = d;
      req_valid[idx]    = 1'b1;
   endtask

   task automatic exp_rsp(input int idx, input logic [31:0] q, input logic err,
                          input int tol, input int lat);
      rsp_t e;
      e.idx = idx;
      e.q   = q;
      e.err = err;
      e.tol = tol;
      e.lat = lat;
      rq.push_back(e);
   endtask

   task automatic wait_for_rsp();
      int n;
      n  = 0;
      rv = '0;
      while (rv == '0) begin
         tick();
         n++;
         if (n > 400) begin
            $display("FAIL wait_rsp: no rsp_valid within 400 cycles");
            $fatal(1);
         end
      end
   endtask

   task automatic ack_rsp(input int hold, input bit nonown);
      repeat (hold) begin
         rsp_ack = nonown ? ~rv : '0;
         tick();
      end
      rsp_ack = rv;
      tick();
      rsp_ack = '0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      // All four at once from pointer 0.
      gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3);
      exp_rsp(0, 32'hddb3d743, 1'b0, 1, 8);
      exp_rsp(1, 32'hfbf7df5c, 1'b0, 1, 8);
      exp_rsp(2, 32'h80000000, 1'b0, 0, 8);
      exp_rsp(3, 32'hddb3d743, 1'b0, 1, 8);
      put(0, 32'hc0000000);
      put(1, 32'hf8000000);
      put(2, 32'h40000000);
      put(3, 32'hc0000000);
      repeat (4) begin
         wait_for_rsp();
         ack_rsp(0, 1'b0);
      end

      // Single request; pointer back at 0.
      gq.push_back(0);
      exp_rsp(0, 32'h80000000, 1'b0, 0, 8);
      put(0, 32'h40000000);
      wait_for_rsp();
      ack_rsp(0, 1'b0);

      // Dead unit: timeout, then stray ready pulses.
      gq.push_back(3);
      exp_rsp(3, 32'h0, 1'b1, 0, 66);
      stub_dead = 1'b1;
      put(3, 32'h40000000);
      wait_for_rsp();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();
      ack_rsp(0, 1'b0);
      stub_dead = 1'b0;
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();

      // Unit busy for 10 cycles at ISSUE.
      gq.push_back(2);
      exp_rsp(2, 32'hddb3d743, 1'b0, 1, 18);
      put(2, 32'hc0000000);
      tick();
      hold_busy = 1'b1;
      repeat (10) tick();
      hold_busy = 1'b0;
      wait_for_rsp();
      ack_rsp(0, 1'b0);

      // Ack withheld 20 cycles, non-owner acks, req 1 waiting.
      gq.push_back(0); gq.push_back(1);
      exp_rsp(0, 32'h40000000, 1'b0, 0, 8);
      exp_rsp(1, 32'hfbf7df5c, 1'b0, 1, 8);
      put(0, 32'h10000000);
      wait_for_rsp();
      put(1, 32'hf8000000);
      ack_rsp(20, 1'b1);
      wait_for_rsp();
      ack_rsp(0, 1'b0);

      // Pointer wrap with 1010 pending, operand extremes.
      gq.push_back(3); gq.push_back(1);
      exp_rsp(3, 32'h00000000, 1'b0, 0, 8);
      exp_rsp(1, 32'hffffffff, 1'b0, 1, 8);
      put(1, 32'hffffffff);
      put(3, 32'h00000000);
      repeat (2) begin
         wait_for_rsp();
         ack_rsp(0, 1'b0);
      end

      // Reset during WAIT drops the request.
      gq.push_back(2);
      put(2, 32'h90000000);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      gq.push_back(2);
      exp_rsp(2, 32'hc0000000, 1'b0, 0, -1);
      put(2, 32'h90000000);
      wait_for_rsp();
      ack_rsp(0, 1'b0);

      done = 1'b1;
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
